// File: rtl/ber_reader_pkg.sv
// ber_reader_pkg
// Shared definitions for the BER snapshot reader: host opcodes, FSM state
// encoding, shadow-bank address map and status-word bit positions.
// No ports; imported by ber_snapshot_reader and snap_word_mux.
package ber_reader_pkg;

  // Host command opcodes carried on i_cmd
  typedef enum logic [1:0] {
    OP_NOP       = 2'b00,
    OP_SNAPSHOT  = 2'b01,
    OP_READ      = 2'b10,
    OP_CLEAR_SEQ = 2'b11
  } opcode_e;

  // Reader FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  // Shadow bank slot order; each 64-bit slot covers two word addresses
  localparam int BANK_BITS_Q  = 0;
  localparam int BANK_ERR_Q   = 1;
  localparam int BANK_BITS_I  = 2;
  localparam int BANK_ERR_I   = 3;
  localparam int BANK_ENTRIES = 4;

  // Word address map
  localparam logic [3:0] ADDR_STATUS = 4'd8;
  localparam logic [3:0] ADDR_MAX    = 4'd8;

  // Returned for any READ beyond ADDR_MAX
  localparam logic [31:0] BAD_ADDR_WORD = 32'hDEAD_BEEF;

  // Status word layout: {snap_valid, 7'b0, seq[7:0], 16'b0}
  localparam int STATUS_VALID_BIT = 31;
  localparam int STATUS_SEQ_LSB   = 16;

endpackage

// File: rtl/snap_word_mux.sv
// snap_word_mux
// Purely combinational word selector for the shadow bank. Slices the
// addressed 64-bit shadow counter into its lo/hi 32-bit word, returns the
// status word at ADDR_STATUS, and flags anything beyond ADDR_MAX.
// Ports:
//   bank_i    : four shadow counters, index order per BANK_* constants
//   status_i  : current status word
//   addr_i    : word address (0..15)
//   word_o    : selected response word
//   illegal_o : high when addr_i is outside the address map
module snap_word_mux
  import ber_reader_pkg::*;
#(
  parameter int CNT_W  = 64,
  parameter int WORD_W = 32
) (
  input  logic [BANK_ENTRIES-1:0][CNT_W-1:0] bank_i,
  input  logic [WORD_W-1:0]                  status_i,
  input  logic [3:0]                         addr_i,
  output logic [WORD_W-1:0]                  word_o,
  output logic                               illegal_o
);

  // Address bits [2:1] pick the counter, bit [0] picks lo/hi half.
  always_comb begin
    word_o    = BAD_ADDR_WORD;
    illegal_o = 1'b1;
    if (addr_i <= ADDR_MAX) begin
      illegal_o = 1'b0;
      if (addr_i == ADDR_STATUS) begin
        word_o = status_i;
      end else if (addr_i[0]) begin
        word_o = bank_i[addr_i[2:1]][WORD_W +: WORD_W];
      end else begin
        word_o = bank_i[addr_i[2:1]][0 +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/ber_snapshot_reader.sv
// ber_snapshot_reader
// Host-side reader for the two-channel BER counters. A SNAPSHOT command
// atomically copies all four 64-bit counters into a shadow bank so the host
// can then fetch them 32 bits at a time without ever seeing a torn value.
// Ports:
//   clock, i_reset (async, active-low)
//   i_bits_count_q/i_error_count_q/i_bits_count_i/i_error_count_i : live counters
//   i_cmd_valid/o_cmd_ready, i_cmd, i_addr : command handshake
//   o_rdata/o_rdata_valid/i_rdata_ready    : response handshake
//   o_addr_err : one-cycle pulse after a READ to an unmapped address
module ber_snapshot_reader
  import ber_reader_pkg::*;
#(
  parameter int CNT_W  = 64,
  parameter int WORD_W = 32,
  parameter int SEQ_W  = 8
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [CNT_W-1:0]  i_bits_count_q,
  input  logic [CNT_W-1:0]  i_error_count_q,
  input  logic [CNT_W-1:0]  i_bits_count_i,
  input  logic [CNT_W-1:0]  i_error_count_i,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  input  logic [3:0]        i_addr,
  output logic              o_cmd_ready,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_rdata_valid,
  input  logic              i_rdata_ready,
  output logic              o_addr_err
);

  state_e                            state_q, state_d;
  logic [BANK_ENTRIES-1:0][CNT_W-1:0] shadow_q, shadow_d;
  logic [BANK_ENTRIES-1:0][CNT_W-1:0] live_bank;
  logic [SEQ_W-1:0]                  seq_q, seq_d;
  logic [SEQ_W-1:0]                  seq_inc;
  logic                              snap_valid_q, snap_valid_d;
  logic [WORD_W-1:0]                 rdata_q, rdata_d;
  logic                              rdata_valid_q, rdata_valid_d;
  logic                              addr_err_q, addr_err_d;
  logic [WORD_W-1:0]                 status_cur;
  logic [WORD_W-1:0]                 mux_word;
  logic                              mux_illegal;

  function automatic logic [WORD_W-1:0] status_word(input logic             valid,
                                                    input logic [SEQ_W-1:0] seq);
    logic [WORD_W-1:0] w;
    w                          = '0;
    w[STATUS_VALID_BIT]        = valid;
    w[STATUS_SEQ_LSB +: SEQ_W] = seq;
    return w;
  endfunction

  assign live_bank[BANK_BITS_Q] = i_bits_count_q;
  assign live_bank[BANK_ERR_Q]  = i_error_count_q;
  assign live_bank[BANK_BITS_I] = i_bits_count_i;
  assign live_bank[BANK_ERR_I]  = i_error_count_i;

  assign seq_inc    = seq_q + 1'b1;
  assign status_cur = status_word(snap_valid_q, seq_q);

  snap_word_mux #(
    .CNT_W  (CNT_W),
    .WORD_W (WORD_W)
  ) u_word_mux (
    .bank_i    (shadow_q),
    .status_i  (status_cur),
    .addr_i    (i_addr),
    .word_o    (mux_word),
    .illegal_o (mux_illegal)
  );

  // Ready is gated by reset so the host sees it low for the whole reset
  // and high on the very first cycle after release.
  assign o_cmd_ready   = (state_q == ST_IDLE) && i_reset;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;
  assign o_addr_err    = addr_err_q;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      seq_q         <= '0;
      snap_valid_q  <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      seq_q         <= seq_d;
      snap_valid_q  <= snap_valid_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Next-state logic. The response word is always registered on the edge
  // that enters RESP, so o_rdata is stable for the whole response phase.
  // addr_err defaults low, which makes it a single-cycle pulse.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    seq_d         = seq_q;
    snap_valid_d  = snap_valid_q;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;
    addr_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          case (opcode_e'(i_cmd))
            OP_SNAPSHOT: begin
              state_d = ST_CAPTURE;
            end
            OP_READ: begin
              rdata_d       = mux_word;
              addr_err_d    = mux_illegal;
              rdata_valid_d = 1'b1;
              state_d       = ST_RESP;
            end
            OP_CLEAR_SEQ: begin
              seq_d         = '0;
              snap_valid_d  = 1'b0;
              rdata_d       = status_word(1'b0, '0);
              rdata_valid_d = 1'b1;
              state_d       = ST_RESP;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      // All four counters land on the same edge; the response reports the
      // post-increment sequence number.
      ST_CAPTURE: begin
        shadow_d      = live_bank;
        seq_d         = seq_inc;
        snap_valid_d  = 1'b1;
        rdata_d       = status_word(1'b1, seq_inc);
        rdata_valid_d = 1'b1;
        state_d       = ST_RESP;
      end

      ST_RESP: begin
        if (i_rdata_ready) begin
          rdata_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        rdata_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ber_snapshot_reader.sv
// tb_ber_snapshot_reader
// Self-checking bench for ber_snapshot_reader: directed scenarios followed by
// randomized commands, compared against an array-based model of the shadow
// bank, sequence counter and address map.
module tb_ber_snapshot_reader;

  localparam logic [1:0] C_NOP   = 2'b00;
  localparam logic [1:0] C_SNAP  = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  logic        clock;
  logic        i_reset;
  logic [63:0] live [4];
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic [3:0]  i_addr;
  logic        o_cmd_ready;
  logic [31:0] o_rdata;
  logic        o_rdata_valid;
  logic        i_rdata_ready;
  logic        o_addr_err;

  int vectors;
  int miscompares;

  // Reference model state
  logic [63:0] mShadow [4];
  int          mSeq;
  bit          mValid;

  ber_snapshot_reader dut (
    .clock           (clock),
    .i_reset         (i_reset),
    .i_bits_count_q  (live[0]),
    .i_error_count_q (live[1]),
    .i_bits_count_i  (live[2]),
    .i_error_count_i (live[3]),
    .i_cmd_valid     (i_cmd_valid),
    .i_cmd           (i_cmd),
    .i_addr          (i_addr),
    .o_cmd_ready     (o_cmd_ready),
    .o_rdata         (o_rdata),
    .o_rdata_valid   (o_rdata_valid),
    .i_rdata_ready   (i_rdata_ready),
    .o_addr_err      (o_addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input int addr);
    logic [63:0] slot;
    if (addr < 8) begin
      slot = mShadow[addr / 2];
      return (addr % 2 == 1) ? slot[63:32] : slot[31:0];
    end
    if (addr == 8) return {mValid, 7'd0, 8'(mSeq), 16'd0};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 4; k++) mShadow[k] = '0;
    mSeq   = 0;
    mValid = 1'b0;
  endtask

  task automatic randomizeLive();
    for (int k = 0; k < 4; k++) live[k] = {$urandom, $urandom};
  endtask

  // Issue one command, wait for the accept, then follow the response
  // through hold cycles and the handshake. Inputs change at posedge+1.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [3:0] addr,
                               input logic [31:0] expWord, input logic expErr,
                               input int hold, input string tag);
    int n;
    int lat;
    int expLat;
    i_cmd_valid = 1'b1;
    i_cmd       = cmd;
    i_addr      = addr;
    n = 0;
    while (!o_cmd_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checkBit({tag, "_ready"}, o_cmd_ready, 1'b1);
    @(posedge clock); #1;
    i_cmd_valid = 1'b0;
    i_cmd       = 2'($urandom);
    i_addr      = 4'($urandom);
    if (cmd == C_NOP) begin
      repeat (3) begin @(posedge clock); #1; end
      checkBit({tag, "_nop_valid"}, o_rdata_valid, 1'b0);
      checkBit({tag, "_nop_ready"}, o_cmd_ready, 1'b1);
      return;
    end
    expLat = (cmd == C_SNAP) ? 2 : 1;
    lat = 1;
    while (!o_rdata_valid && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    checkInt({tag, "_latency"}, lat, expLat);
    checkWord({tag, "_word"}, o_rdata, expWord);
    checkBit({tag, "_addr_err"}, o_addr_err, expErr);
    for (int h = 0; h < hold; h++) begin
      // A command offered while busy must be ignored
      i_cmd_valid = 1'b1;
      i_cmd       = C_SNAP;
      @(posedge clock); #1;
      checkBit({tag, "_hold_valid"}, o_rdata_valid, 1'b1);
      checkWord({tag, "_hold_word"}, o_rdata, expWord);
      checkBit({tag, "_hold_ready"}, o_cmd_ready, 1'b0);
      checkBit({tag, "_hold_err"}, o_addr_err, 1'b0);
    end
    i_cmd_valid   = 1'b0;
    i_rdata_ready = 1'b1;
    @(posedge clock); #1;
    i_rdata_ready = 1'b0;
    checkBit({tag, "_done_valid"}, o_rdata_valid, 1'b0);
    checkBit({tag, "_done_ready"}, o_cmd_ready, 1'b1);
    checkBit({tag, "_done_err"}, o_addr_err, 1'b0);
  endtask

  task automatic snapStep(input int hold);
    for (int k = 0; k < 4; k++) mShadow[k] = live[k];
    mSeq   = (mSeq + 1) % 256;
    mValid = 1'b1;
    applyStimulus(C_SNAP, 4'($urandom), modelRead(8), 1'b0, hold, "snap");
  endtask

  task automatic readStep(input int addr, input int hold);
    applyStimulus(C_READ, 4'(addr), modelRead(addr), (addr > 8), hold, "read");
  endtask

  task automatic clearStep(input int hold);
    mSeq   = 0;
    mValid = 1'b0;
    applyStimulus(C_CLEAR, 4'($urandom), modelRead(8), 1'b0, hold, "clear");
  endtask

  task automatic checkOutput(input string tag, input logic expReady);
    checkBit({tag, "_ready"}, o_cmd_ready, expReady);
    checkBit({tag, "_valid"}, o_rdata_valid, 1'b0);
    checkWord({tag, "_rdata"}, o_rdata, 32'h0);
    checkBit({tag, "_err"}, o_addr_err, 1'b0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    i_reset       = 1'b0;
    i_cmd_valid   = 1'b0;
    i_cmd         = C_NOP;
    i_addr        = 4'd0;
    i_rdata_ready = 1'b0;
    randomizeLive();
    modelReset();

    // Reset state and release
    #22;
    checkOutput("in_reset", 1'b0);
    @(posedge clock); #1;
    i_reset = 1'b1;
    #1;
    checkBit("release_ready", o_cmd_ready, 1'b1);

    // Status before any snapshot, then a NOP
    readStep(8, 0);
    readStep(3, 0);
    applyStimulus(C_NOP, 4'd0, 32'h0, 1'b0, 0, "nop");

    // First snapshot with a known bits_q value, then reads see captured data
    live[0] = 64'h0000_0001_2345_6789;
    snapStep(0);
    checkWord("first_status", modelRead(8), 32'h8001_0000);
    randomizeLive();
    readStep(0, 0);
    readStep(1, 0);
    checkWord("model_lo", modelRead(0), 32'h2345_6789);
    checkWord("model_hi", modelRead(1), 32'h0000_0001);

    // Response held for five cycles while host stalls
    readStep(5, 5);

    // Illegal address
    readStep(12, 2);
    readStep(15, 0);
    readStep(9, 0);

    // Sequence wrap: 256 snapshots bring seq back to zero, then clear
    clearStep(0);
    for (int s = 0; s < 256; s++) begin
      randomizeLive();
      snapStep(0);
    end
    checkWord("wrap_status", modelRead(8), 32'h8000_0000);
    readStep(8, 0);
    clearStep(1);
    readStep(8, 0);

    // Randomized command mix
    for (int i = 0; i < 60; i++) begin
      int r;
      if ($urandom_range(0, 1) == 1) randomizeLive();
      r = $urandom_range(0, 9);
      if (r <= 2)      snapStep($urandom_range(0, 2));
      else if (r <= 7) readStep($urandom_range(0, 15), $urandom_range(0, 2));
      else if (r == 8) clearStep($urandom_range(0, 2));
      else             applyStimulus(C_NOP, 4'($urandom), 32'h0, 1'b0, 0, "rnd_nop");
    end

    // Reset asserted while a response is pending
    randomizeLive();
    snapStep(0);
    i_cmd_valid = 1'b1;
    i_cmd       = C_READ;
    i_addr      = 4'd6;
    @(posedge clock); #1;
    i_cmd_valid = 1'b0;
    checkBit("pre_reset_valid", o_rdata_valid, 1'b1);
    #2;
    i_reset = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_reset", 1'b0);
    @(posedge clock); #1;
    i_reset = 1'b1;
    #1;
    checkBit("rerelease_ready", o_cmd_ready, 1'b1);
    readStep(6, 0);
    readStep(7, 0);
    readStep(8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
